mem_wb_pipe: RTL and testbench

//  MEM/WB pipeline register with memory-wait control, between the memory stage and register-file writeback.
//  - Captures each retiring instruction's result and selects load data or ALU data as the writeback value.
//  - Holds the pipeline (oStall) while a data-memory access is not ready.
//  - Latches a sticky halt when a halt instruction retires.

---
 rtl/cpu_defines_pkg.sv | 12 +
 rtl/mem_wb_pipe.sv | 114 +++++++++++
 tb/tb_mem_wb_pipe.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_defines_pkg.sv
// Shared CPU definitions: MEM/WB FSM state encodings and the hard-wired zero register.
package cpu_defines;

  typedef enum logic [1:0] {
    MEMWB_RUN  = 2'd0,
    MEMWB_WAIT = 2'd1,
    MEMWB_HALT = 2'd2
  } memwb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with data-memory wait handling and sticky halt.
// Optional stall-cycle counter enabled by defining MEM_WB_STALL_CNT_EN.
module mem_wb_pipe
  import cpu_defines::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iExuData,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemToReg,
  input  logic              iMemAccess,
  input  logic              iMemReady,
  input  logic [ADDR_W-1:0] iWriteAddr,
  input  logic              iWriteEn,
  input  logic              iHalt,
  output logic [DATA_W-1:0] oWriteData,
  output logic [ADDR_W-1:0] oWriteAddr,
  output logic              oWriteEn,
  output logic              oStall,
  output logic              oHalted,
  output logic [CNT_W-1:0]  oStallCount
);

  memwb_state_e      state_q, state_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              wen_q, wen_d;
  logic              halted_q, halted_d;
  logic              accept;
  logic              stall;

  always_comb begin
    state_d  = state_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    wen_d    = 1'b0;
    halted_d = halted_q;
    stall    = 1'b0;
    accept   = iValid & (~iMemAccess | iMemReady) & (state_q != MEMWB_HALT);

    case (state_q)
      MEMWB_RUN: begin
        stall = iValid & iMemAccess & ~iMemReady;
        if (stall)
          state_d = MEMWB_WAIT;
        else if (accept && iHalt)
          state_d = MEMWB_HALT;
      end
      MEMWB_WAIT: begin
        stall = ~iMemReady;
        if (iMemReady)
          state_d = (accept && iHalt) ? MEMWB_HALT : MEMWB_RUN;
      end
      MEMWB_HALT: stall = 1'b1;
      default:    state_d = MEMWB_RUN;
    endcase

    // A halt still retires its own writeback in the accepting cycle.
    if (accept) begin
      wdata_d  = iMemToReg ? iMemData : iExuData;
      waddr_d  = iWriteAddr;
      wen_d    = iWriteEn & (iWriteAddr != ADDR_W'(REG_ZERO));
      halted_d = halted_q | iHalt;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= MEMWB_RUN;
      wdata_q  <= '0;
      waddr_q  <= '0;
      wen_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
      wen_q    <= wen_d;
      halted_q <= halted_d;
    end
  end

`ifdef MEM_WB_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of stall cycles; halted cycles are excluded.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (state_q != MEMWB_HALT) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign oStallCount = cnt_q;
`else
  assign oStallCount = '0;
`endif

  assign oWriteData = wdata_q;
  assign oWriteAddr = waddr_q;
  assign oWriteEn   = wen_q;
  assign oStall     = stall;
  assign oHalted    = halted_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe (honours MEM_WB_STALL_CNT_EN if defined).
module tb_mem_wb_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid, mem_to_reg, mem_access, mem_ready, wen, halt;
  logic [DATA_W-1:0] exu_data, mem_data;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] o_wdata;
  logic [ADDR_W-1:0] o_waddr;
  logic              o_wen, o_stall, o_halted;
  logic [CNT_W-1:0]  o_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .iClk(clk), .iRst_n(rst_n), .iValid(valid), .iExuData(exu_data), .iMemData(mem_data),
    .iMemToReg(mem_to_reg), .iMemAccess(mem_access), .iMemReady(mem_ready),
    .iWriteAddr(waddr), .iWriteEn(wen), .iHalt(halt),
    .oWriteData(o_wdata), .oWriteAddr(o_waddr), .oWriteEn(o_wen), .oStall(o_stall),
    .oHalted(o_halted), .oStallCount(o_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; mem_to_reg = 0; mem_access = 0; mem_ready = 0; wen = 0; halt = 0;
    exu_data = '0; mem_data = '0; waddr = '0;
  endtask

  task automatic set_op(input logic v, input logic acc, input logic rdy, input logic m2r,
                        input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] exu, input logic [DATA_W-1:0] mem,
                        input logic h);
    valid = v; mem_access = acc; mem_ready = rdy; mem_to_reg = m2r;
    wen = we; waddr = a; exu_data = exu; mem_data = mem; halt = h;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    step();
    step();
    check("rst_wdata",  o_wdata,  0);
    check("rst_wen",    o_wen,    0);
    check("rst_halted", o_halted, 0);
    check("rst_cnt",    o_cnt,    0);
    rst_n = 1;
    step();

    // ALU op
    set_op(1, 0, 0, 0, 1, 5'd5, 32'h1234, 32'h0, 0);
    #1 check("alu_stall", o_stall, 0);
    step();
    check("alu_wen",   o_wen,   1);
    check("alu_waddr", o_waddr, 5);
    check("alu_wdata", o_wdata, 32'h1234);
    idle_inputs();
    step();
    check("bubble_wen",   o_wen,   0);
    check("bubble_wdata", o_wdata, 32'h1234);

    // Write to r0 is suppressed but data still captured
    set_op(1, 0, 0, 0, 1, 5'd0, 32'hFFFF, 32'h0, 0);
    step();
    check("r0_wen",   o_wen,   0);
    check("r0_wdata", o_wdata, 32'hFFFF);

    // Load miss: three stall cycles, then ready
    set_op(1, 1, 0, 1, 1, 5'd7, 32'h1111, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("miss_stall%0d", i), o_stall, 1);
      step();
      check($sformatf("miss_wen%0d", i), o_wen, 0);
    end
    mem_ready = 1; mem_data = 32'hDEADBEEF;
    #1 check("miss_ready_stall", o_stall, 0);
    step();
    check("miss_wdata", o_wdata, 32'hDEADBEEF);
    check("miss_wen",   o_wen,   1);
    check("miss_waddr", o_waddr, 7);
`ifdef MEM_WB_STALL_CNT_EN
    check("miss_cnt", o_cnt, 3);
`else
    check("miss_cnt", o_cnt, 0);
`endif

    // Store hit in request cycle: no stall, no write, stays in RUN
    set_op(1, 1, 1, 0, 0, 5'd2, 32'hAAAA, 32'h0, 0);
    #1 check("store_stall", o_stall, 0);
    step();
    check("store_wen",   o_wen,   0);
    check("store_wdata", o_wdata, 32'hAAAA);
    set_op(1, 0, 0, 0, 1, 5'd9, 32'h55, 32'h0, 0);
    #1 check("post_store_stall", o_stall, 0);
    step();
    check("post_store_wen",   o_wen,   1);
    check("post_store_wdata", o_wdata, 32'h55);

    // Reset in the middle of a memory wait
    set_op(1, 1, 0, 1, 1, 5'd6, 32'h0, 32'h0, 0);
    step();
    step();
    #1 check("wait_stall", o_stall, 1);
    idle_inputs();
    rst_n = 0;
    #1;
    check("midrst_wdata",  o_wdata,  0);
    check("midrst_waddr",  o_waddr,  0);
    check("midrst_wen",    o_wen,    0);
    check("midrst_halted", o_halted, 0);
    check("midrst_cnt",    o_cnt,    0);
    step();
    rst_n = 1;
    step();
    set_op(1, 0, 0, 0, 1, 5'd4, 32'h42, 32'h0, 0);
    #1 check("postrst_stall", o_stall, 0);
    step();
    check("postrst_wen",   o_wen,   1);
    check("postrst_wdata", o_wdata, 32'h42);

    // Halt retires its own write, then everything is frozen
    set_op(1, 0, 0, 0, 1, 5'd3, 32'h77, 32'h0, 1);
    step();
    check("halt_halted", o_halted, 1);
    check("halt_wen",    o_wen,    1);
    check("halt_waddr",  o_waddr,  3);
    set_op(1, 0, 0, 0, 1, 5'd8, 32'h99, 32'h0, 0);
    #1 check("halt_stall", o_stall, 1);
    step();
    check("halted_wen",   o_wen,    0);
    check("halted_wdata", o_wdata,  32'h77);
    step();
    check("halted_sticky", o_halted, 1);
    check("halted_cnt",    o_cnt,    0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
